// File: rtl/fifo_wptr_full.sv
// Write-side pointer logic for a dual-clock FIFO: binary/Gray write counter,
// read-pointer synchroniser, registered full flag and write-side occupancy.
module fifo_wptr_full #(
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr_gray,
    output logic             wfull,
    output logic [ASIZE:0]   wcount
);

    logic [ASIZE:0] wbin_reg;
    logic [ASIZE:0] wgray_reg;
    logic           wfull_reg;
    logic [ASIZE:0] sync_reg [SYNC_STAGES];

    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] rq_gray;
    logic [ASIZE:0] rq_bin;
    logic [ASIZE:0] full_gray;
    logic           wen;

    // Uses the registered flag, so a write on the edge where wfull drops is still refused.
    assign wen        = winc & ~wfull_reg;
    assign wbin_next  = wbin_reg + {{ASIZE{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    assign rq_gray   = sync_reg[SYNC_STAGES-1];
    assign full_gray = {~rq_gray[ASIZE:ASIZE-1], rq_gray[ASIZE-2:0]};

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    assign rq_bin[ASIZE] = rq_gray[ASIZE];
    genvar gi;
    generate
        for (gi = ASIZE - 1; gi >= 0; gi--) begin : g_g2b
            assign rq_bin[gi] = rq_bin[gi+1] ^ rq_gray[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            wfull_reg <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            wfull_reg <= (wgray_next == full_gray);
        end
    end

    assign waddr     = wbin_reg[ASIZE-1:0];
    assign wptr_gray = wgray_reg;
    assign wfull     = wfull_reg;
    assign wcount    = wbin_reg - rq_bin;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ASIZE=2, SYNC_STAGES=2.
module tb_fifo_wptr_full;

    localparam int ASIZE = 2;

    logic             clk;
    logic             rst_n;
    logic             winc;
    logic [ASIZE:0]   rptr_gray;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr_gray;
    logic             wfull;
    logic [ASIZE:0]   wcount;

    int checks   = 0;
    int failures = 0;

    fifo_wptr_full #(.ASIZE(ASIZE), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
        .wfull     (wfull),
        .wcount    (wcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with winc driven; returns on the following negedge for sampling.
    task automatic step(input logic w);
        winc = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    logic [ASIZE:0] gray_exp [8];
    logic [ASIZE:0] prev_gray;
    logic [ASIZE:0] rd;
    int             done;

    initial begin
        gray_exp[0] = 3'b001; gray_exp[1] = 3'b011; gray_exp[2] = 3'b010; gray_exp[3] = 3'b110;
        gray_exp[4] = 3'b111; gray_exp[5] = 3'b101; gray_exp[6] = 3'b100; gray_exp[7] = 3'b000;

        rst_n     = 1'b1;
        winc      = 1'b0;
        rptr_gray = '0;

        // Test 1: reset without any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("reset_wptr",   32'(wptr_gray), 32'h0);
        check("reset_waddr",  32'(waddr),     32'h0);
        check("reset_wfull",  32'(wfull),     32'h0);
        check("reset_wcount", 32'(wcount),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: fill four slots
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            $display("fill %0d: wptr_gray=%b waddr=%0d wfull=%0d wcount=%0d", i, wptr_gray, waddr, wfull, wcount);
            check("fill_wptr",  32'(wptr_gray), 32'(gray_exp[i]));
            check("fill_waddr", 32'(waddr),     32'((i + 1) % 4));
            check("fill_wfull", 32'(wfull),     (i == 3) ? 32'h1 : 32'h0);
        end
        check("fill_wcount", 32'(wcount), 32'h4);

        // Test 3: overrun attempts are ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            $display("overrun %0d: wptr_gray=%b waddr=%0d wfull=%0d", i, wptr_gray, waddr, wfull);
            check("ovr_wptr",  32'(wptr_gray), 32'h6);
            check("ovr_waddr", 32'(waddr),     32'h0);
            check("ovr_wfull", 32'(wfull),     32'h1);
        end

        // Test 4: release after the read pointer advances; winc held high throughout
        rptr_gray = 3'b001;
        step(1'b1);
        $display("release e1: wfull=%0d wcount=%0d", wfull, wcount);
        check("rel_e1_wfull", 32'(wfull), 32'h1);
        step(1'b1);
        $display("release e2: wfull=%0d wcount=%0d", wfull, wcount);
        check("rel_e2_wfull", 32'(wfull), 32'h1);
        check("rel_e2_wptr",  32'(wptr_gray), 32'h6);
        step(1'b1);
        $display("release e3: wfull=%0d wcount=%0d wptr_gray=%b", wfull, wcount, wptr_gray);
        check("rel_e3_wfull",  32'(wfull),     32'h0);
        check("rel_e3_wcount", 32'(wcount),    32'h3);
        check("rel_e3_wptr",   32'(wptr_gray), 32'h6);
        winc = 1'b0;

        // Test 5: wrap with the reader trailing two writes behind
        rptr_gray = '0;
        do_reset();
        prev_gray = wptr_gray;
        for (int w = 0; w < 8; w++) begin
            done = (w >= 2) ? w - 2 : 0;
            rd = 3'(done);
            rptr_gray = (rd >> 1) ^ rd;
            for (int k = 0; k < 3; k++) step(1'b0);
            step(1'b1);
            $display("wrap %0d: wptr_gray=%b waddr=%0d wfull=%0d wcount=%0d", w, wptr_gray, waddr, wfull, wcount);
            check("wrap_wptr",   32'(wptr_gray), 32'(gray_exp[w]));
            check("wrap_wfull",  32'(wfull),     32'h0);
            check("wrap_onebit", 32'($countones(prev_gray ^ wptr_gray)), 32'h1);
            check("wrap_wcount", 32'(wcount),    32'(w + 1 - done));
            prev_gray = wptr_gray;
        end
        winc = 1'b0;

        // Test 6: reset in the middle of operation
        rptr_gray = '0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        winc = 1'b0;
        check("pre_rst_wptr", 32'(wptr_gray), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        $display("midreset: wptr_gray=%b waddr=%0d wfull=%0d wcount=%0d", wptr_gray, waddr, wfull, wcount);
        check("mid_rst_wptr",   32'(wptr_gray), 32'h0);
        check("mid_rst_waddr",  32'(waddr),     32'h0);
        check("mid_rst_wfull",  32'(wfull),     32'h0);
        check("mid_rst_wcount", 32'(wcount),    32'h0);
        #1 rst_n = 1'b1;
        step(1'b1);
        winc = 1'b0;
        $display("post-reset write: wptr_gray=%b waddr=%0d", wptr_gray, waddr);
        check("post_rst_wptr",  32'(wptr_gray), 32'h1);
        check("post_rst_waddr", 32'(waddr),     32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
